// File: rtl/sync_arith_29_pkg.sv
// Shared definitions for the sync_arith_29 command path: widths, opcodes,
// status bit positions and the sequencer state encoding.
package sync_arith_29_pkg;

  localparam int unsigned SA_M   = 32;
  localparam int unsigned SA_OPW = 4;
  localparam int unsigned SA_STW = 4;

  localparam logic [SA_OPW-1:0] OP_ADD   = 4'h0;
  localparam logic [SA_OPW-1:0] OP_SUB   = 4'h1;
  localparam logic [SA_OPW-1:0] OP_AND   = 4'h2;
  localparam logic [SA_OPW-1:0] OP_OR    = 4'h3;
  localparam logic [SA_OPW-1:0] OP_XOR   = 4'h4;
  localparam logic [SA_OPW-1:0] OP_PASSA = 4'h5;

  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_C = 2;
  localparam int unsigned STAT_V = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } sa_state_e;

endpackage

// File: rtl/sync_arith_cmd_fifo_29.sv
// Register-based command FIFO; push is ignored when full, pop when empty.
module sync_arith_cmd_fifo_29 #(
  parameter int unsigned W     = 68,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [W-1:0]    mem_q [DEPTH];
  logic [W-1:0]    mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign o_full  = (count_q == CNTW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = mem_q[rd_ptr_q];

  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  // Pointers are AW bits wide, so wrap modulo DEPTH falls out of the overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sync_arith_seq_29.sv
// Command sequencer for the synchronous ALU: queues commands, issues one at a
// time, waits the ALU latency and returns the captured result/status.
module sync_arith_seq_29
  import sync_arith_29_pkg::*;
#(
  parameter int unsigned M     = SA_M,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [M-1:0] i_cmd_A,
  input  logic [M-1:0] i_cmd_B,
  input  logic [3:0]   i_cmd_op,
  output logic [M-1:0] o_alu_A,
  output logic [M-1:0] o_alu_B,
  output logic [3:0]   o_alu_op,
  input  logic [M-1:0] i_alu_result,
  input  logic [3:0]   i_alu_status,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [M-1:0] o_rsp_result,
  output logic [3:0]   o_rsp_status,
  output logic         o_busy
);

  localparam int unsigned W  = 2 * M + SA_OPW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  sa_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  alu_a_q, alu_a_d;
  logic [M-1:0]  alu_b_q, alu_b_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [M-1:0]  rsp_result_q, rsp_result_d;
  logic [3:0]    rsp_status_q, rsp_status_d;

  logic          fifo_push, fifo_pop;
  logic [W-1:0]  fifo_head;
  logic          fifo_full, fifo_empty;
  logic [AW:0]   fifo_count;
  logic          issue;

  assign fifo_push = i_cmd_valid & ~fifo_full;

  sync_arith_cmd_fifo_29 #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (i_reset),
    .i_push  (fifo_push),
    .i_data  ({i_cmd_A, i_cmd_B, i_cmd_op}),
    .i_pop   (fifo_pop),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  // An issue can come either from IDLE or straight out of RESP on the
  // consuming edge, so the load/pop is factored out after the state case.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_status_d = rsp_status_q;
    issue        = 1'b0;
    fifo_pop     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) issue = 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = i_alu_result;
          rsp_status_d = i_alu_status;
          rsp_valid_d  = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) issue = 1'b1;
          else             state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      fifo_pop                       = 1'b1;
      {alu_a_d, alu_b_d, alu_op_d}   = fifo_head;
      cnt_d                          = CW'(LAT);
      state_d                        = S_WAIT;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_status_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  assign o_cmd_ready  = ~fifo_full;
  assign o_alu_A      = alu_a_q;
  assign o_alu_B      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_status = rsp_status_q;
  assign o_busy       = (fifo_count != '0) | (state_q != S_IDLE);

endmodule

// File: tb/tb_sync_arith_seq_29.sv
// Bench for sync_arith_seq_29 with a registered one-clock ALU stand-in and a
// response-queue reference model.
module tb_sync_arith_seq_29;
  import sync_arith_29_pkg::*;

  localparam int unsigned M     = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LAT   = 1;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_cmd_valid;
  logic         o_cmd_ready;
  logic [M-1:0] i_cmd_A, i_cmd_B;
  logic [3:0]   i_cmd_op;
  logic [M-1:0] o_alu_A, o_alu_B;
  logic [3:0]   o_alu_op;
  logic [M-1:0] alu_result = '0;
  logic [3:0]   alu_status = '0;
  logic         o_rsp_valid;
  logic         i_rsp_ready;
  logic [M-1:0] o_rsp_result;
  logic [3:0]   o_rsp_status;
  logic         o_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rsp_cnt = 0;
  logic [35:0] exp_q[$];

  always #5 clk = ~clk;

  sync_arith_seq_29 #(.M(M), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_cmd_A      (i_cmd_A),
    .i_cmd_B      (i_cmd_B),
    .i_cmd_op     (i_cmd_op),
    .o_alu_A      (o_alu_A),
    .o_alu_B      (o_alu_B),
    .o_alu_op     (o_alu_op),
    .i_alu_result (alu_result),
    .i_alu_status (alu_status),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_result (o_rsp_result),
    .o_rsp_status (o_rsp_status),
    .o_busy       (o_busy)
  );

  // Returns {status, result} for one ALU operation.
  function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    logic [32:0] wide;
    logic [31:0] r;
    logic [3:0]  st;
    st = '0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[31:0];
        st[STAT_C] = wide[32];
        st[STAT_V] = (a[31] == b[31]) && (r[31] != a[31]);
      end
      OP_SUB: begin
        r = a - b;
        st[STAT_C] = (a < b);
        st[STAT_V] = (a[31] != b[31]) && (r[31] != a[31]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = a;
    endcase
    st[STAT_Z] = (r == '0);
    st[STAT_N] = r[31];
    return {st, r};
  endfunction

  always @(posedge clk) {alu_status, alu_result} <= alu_fn(o_alu_A, o_alu_B, o_alu_op);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Handshakes are sampled mid-cycle, where inputs are stable up to the next edge.
  always @(negedge clk) begin
    if (!i_reset) begin
      exp_q.delete();
    end else begin
      chk("busy", o_busy, exp_q.size() != 0);
      chk("outstanding_bound", exp_q.size() <= DEPTH + 1, 1'b1);
      if (o_rsp_valid && i_rsp_ready) begin
        rsp_cnt++;
        if (exp_q.size() == 0) fail("rsp_unexpected");
        else chk("rsp_data", {o_rsp_status, o_rsp_result}, exp_q.pop_front());
      end
      if (i_cmd_valid && o_cmd_ready) exp_q.push_back(alu_fn(i_cmd_A, i_cmd_B, i_cmd_op));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    i_cmd_A  = a;
    i_cmd_B  = b;
    i_cmd_op = op;
  endtask

  task automatic push_one(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit got;
    got = 0;
    set_cmd(a, b, op);
    i_cmd_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (o_cmd_ready) begin
        got = 1;
        break;
      end
      tick();
    end
    if (got) tick();
    else fail("push_timeout");
    i_cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    chk(nm, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc, base, n;
    bit got;
    logic [31:0] xa, xb, ya, yb;
    logic [3:0]  xop, yop;

    tbl[0] = '{32'd5,        32'd3,        OP_ADD, 32'd8,        4'h0};
    tbl[1] = '{32'd3,        32'd5,        OP_SUB, 32'hFFFF_FFFE, 4'h6};
    tbl[2] = '{32'hF0F0_0000, 32'h0F0F_0000, OP_AND, 32'h0,        4'h1};
    tbl[3] = '{32'hFFFF_FFFF, 32'd1,        OP_ADD, 32'h0,        4'h5};
    tbl[4] = '{32'h7FFF_FFFF, 32'd1,        OP_ADD, 32'h8000_0000, 4'hA};
    tbl[5] = '{32'hAAAA_AAAA, 32'hFFFF_FFFF, OP_XOR, 32'h5555_5555, 4'h0};
    tbl[6] = '{32'h12,       32'h30,       OP_OR,  32'h32,       4'h0};

    // Reset
    i_reset = 1'b0;
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b0;
    set_cmd('0, '0, '0);
    repeat (2) tick();
    chk("rst_outs", {o_alu_A, o_alu_B, o_alu_op, o_rsp_valid, o_rsp_result, o_rsp_status}, '0);
    chk("rst_ready", o_cmd_ready, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    i_reset = 1'b1;
    tick();
    chk("post_rst_outs", {o_alu_A, o_alu_B, o_alu_op, o_rsp_valid, o_rsp_result, o_rsp_status}, '0);
    chk("post_rst_ready", o_cmd_ready, 1'b1);

    // Single-op latency, one vector at a time
    for (int i = 0; i < 7; i++) begin
      set_cmd(tbl[i].a, tbl[i].b, tbl[i].op);
      i_cmd_valid = 1'b1;
      chk("tbl_ready", o_cmd_ready, 1'b1);
      tick();
      i_cmd_valid = 1'b0;
      tick();
      chk("tbl_issue", {o_alu_A, o_alu_B, o_alu_op}, {tbl[i].a, tbl[i].b, tbl[i].op});
      chk("tbl_valid_e1", o_rsp_valid, 1'b0);
      tick();
      chk("tbl_valid_e2", o_rsp_valid, 1'b0);
      tick();
      chk("tbl_valid_e3", o_rsp_valid, 1'b1);
      chk("tbl_rsp", {o_rsp_status, o_rsp_result}, {tbl[i].st, tbl[i].res});
      i_rsp_ready = 1'b1;
      tick();
      chk("tbl_rsp_drop", o_rsp_valid, 1'b0);
      i_rsp_ready = 1'b0;
    end

    // Fill: one in flight plus DEPTH queued
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      set_cmd(i, 0, OP_ADD);
      i_cmd_valid = 1'b1;
      if (!o_cmd_ready) break;
      tick();
      acc++;
    end
    chk("fill_accepted", acc, 5);
    chk("fill_ready_low", o_cmd_ready, 1'b0);
    i_rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 40; k++) begin
      if (o_cmd_ready) begin
        tick();
        got = 1;
        break;
      end
      tick();
    end
    chk("fill_6th_accepted", got, 1'b1);
    i_cmd_valid = 1'b0;
    drain("fill_drain");

    // Backpressure with a second command queued
    i_rsp_ready = 1'b0;
    xa = $urandom; xb = $urandom; xop = 4'($urandom_range(0, 5));
    ya = $urandom; yb = $urandom; yop = 4'($urandom_range(0, 5));
    push_one(xa, xb, xop);
    push_one(ya, yb, yop);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_rsp_valid) begin
        got = 1;
        break;
      end
      tick();
    end
    chk("bp_rsp_arrives", got, 1'b1);
    repeat (10) begin
      tick();
      chk("bp_hold", {o_rsp_valid, o_rsp_status, o_rsp_result, o_alu_A, o_alu_B, o_alu_op},
          {1'b1, alu_fn(xa, xb, xop), xa, xb, xop});
    end
    i_rsp_ready = 1'b1;
    tick();
    chk("bp_resume_issue", {o_alu_A, o_alu_B, o_alu_op}, {ya, yb, yop});
    chk("bp_resume_drop", o_rsp_valid, 1'b0);
    drain("bp_drain");

    // Continuous stream with simultaneous push/pop
    base = rsp_cnt;
    n = 0;
    i_rsp_ready = 1'b1;
    set_cmd($urandom, $urandom, 4'($urandom_range(0, 5)));
    i_cmd_valid = 1'b1;
    for (int cyc = 0; cyc < 300 && n < 12; cyc++) begin
      if (o_cmd_ready) begin
        tick();
        n++;
        set_cmd($urandom, $urandom, 4'($urandom_range(0, 5)));
      end else begin
        tick();
      end
    end
    i_cmd_valid = 1'b0;
    chk("stream_accepted", n, 12);
    drain("stream_drain");
    chk("stream_rsp_count", rsp_cnt - base, 12);

    // Random soak
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_cmd($urandom, $urandom, 4'($urandom_range(0, 7)));
      i_cmd_valid = 1'($urandom_range(0, 1));
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_cmd_valid = 1'b0;
    i_rsp_ready = 1'b1;
    drain("soak_drain");

    // Reset one clock after an issue with two commands queued
    push_one(32'd11, 32'd1, OP_ADD);
    push_one(32'd22, 32'd2, OP_SUB);
    push_one(32'd33, 32'd3, OP_XOR);
    i_reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", o_rsp_valid, 1'b0);
    chk("midrst_busy", o_busy, 1'b0);
    chk("midrst_ready", o_cmd_ready, 1'b1);
    chk("midrst_alu", {o_alu_A, o_alu_B, o_alu_op}, '0);
    base = rsp_cnt;
    repeat (2) tick();
    i_reset = 1'b1;
    repeat (12) tick();
    chk("midrst_no_rsp", rsp_cnt - base, 0);
    chk("midrst_idle_busy", o_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
